// File: rtl/instr_fetch_bridge.sv
// instr_fetch_bridge: single-entry buffered instruction fetch from external space (pc[31]=1), abandoning a fetch after TIMEOUT wait cycles with NOP_INSTR
module instr_fetch_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        suspend,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic        ext_req,
  output logic [31:0] ext_addr,
  output logic [31:0] instr,
  output logic        valid,
  output logic        valid_reg,
  output logic        fetch_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t        state_q;
  logic [29:0]   buf_addr_q;
  logic [31:0]   buf_data_q;
  logic          buf_vld_q;
  logic [31:0]   data_q;
  logic [CW-1:0] cnt_q;
  logic          ext_req_q;
  logic [31:0]   ext_addr_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          valid_reg_q;
  logic          fetch_err_q;
  logic          hit;
  logic          last_wait;
  logic          unused_pc;
  assign hit       = pc[31] & buf_vld_q & (pc[31:2] == buf_addr_q);
  assign last_wait = cnt_q == CW'(TIMEOUT - 1);
  assign unused_pc = ^pc[1:0];
  assign ext_req   = ext_req_q;
  assign ext_addr  = ext_addr_q;
  assign instr     = instr_q;
  assign valid     = valid_q;
  assign valid_reg = valid_reg_q;
  assign fetch_err = fetch_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_vld_q   <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      valid_reg_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      valid_reg_q <= valid_q;
      case (state_q)
        IDLE: begin
          valid_q <= hit;
          if (hit) instr_q <= buf_data_q;
          if (pc[31] && !hit && !suspend) begin
            state_q    <= REQ;
            ext_req_q  <= 1'b1;
            ext_addr_q <= {pc[31:2], 2'b00};
            cnt_q      <= '0;
          end
        end
        REQ: begin
          valid_q <= 1'b0;
          if (ext_ack) begin
            data_q    <= ext_rdata;
            ext_req_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (ext_ack) begin
            data_q    <= ext_rdata;
            ext_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (last_wait) begin
            ext_req_q   <= 1'b0;
            fetch_err_q <= 1'b1;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b1;
            buf_vld_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // data for a word the core has since left is dropped; IDLE refetches
          if (ext_addr_q[31:2] == pc[31:2]) begin
            buf_addr_q <= pc[31:2];
            buf_data_q <= data_q;
            buf_vld_q  <= 1'b1;
            instr_q    <= data_q;
            valid_q    <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_bridge.sv
// tb_instr_fetch_bridge: directed vectors, corner sequences and random run against a transaction-level model
module tb_instr_fetch_bridge;
  localparam int TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A = 32'h8000_0040;
  localparam logic [31:0] B = 32'h8000_0044;
  localparam logic [31:0] C = 32'h8000_0080;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic suspend = 1'b0;
  logic ext_ack = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] ext_rdata = '0;
  logic ext_req, valid, valid_reg, fetch_err;
  logic [31:0] ext_addr, instr;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        req;
    logic        val;
    logic [31:0] ins;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[21];
  logic [31:0] pcs[5];
  logic        m_busy, m_has, m_bv, m_val, m_vr, m_err, m_req, m_hit;
  int          m_age;
  logic [29:0] m_ba;
  logic [31:0] m_bd, m_rd, m_ins, m_addr;
  instr_fetch_bridge #(.TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc(pc), .suspend(suspend),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_req(ext_req),
    .ext_addr(ext_addr), .instr(instr), .valid(valid),
    .valid_reg(valid_reg), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [31:0] p, input logic s, input logic a, input logic [31:0] d);
    @(negedge clk);
    reset = r;
    pc = p;
    suspend = s;
    ext_ack = a;
    ext_rdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic model_edge();
    if (reset) begin
      {m_busy, m_has, m_bv, m_val, m_vr, m_err, m_req} = '0;
      m_age = 0;
      m_ins = '0;
      m_addr = '0;
    end else begin
      m_vr = m_val;
      m_hit = pc[31] && m_bv && pc[31:2] == m_ba;
      if (m_has) begin
        m_has = 1'b0;
        m_val = pc[31:2] == m_addr[31:2];
        if (m_val) begin
          m_bv = 1'b1;
          m_ba = pc[31:2];
          m_bd = m_rd;
          m_ins = m_rd;
        end
      end else if (m_busy) begin
        m_val = 1'b0;
        if (ext_ack) begin
          m_busy = 1'b0;
          m_has = 1'b1;
          m_rd = ext_rdata;
          m_req = 1'b0;
        end else if (m_age == TO) begin
          m_busy = 1'b0;
          m_req = 1'b0;
          m_err = 1'b1;
          m_ins = NOP;
          m_val = 1'b1;
          m_bv = 1'b0;
        end else begin
          m_age++;
        end
      end else begin
        m_val = m_hit;
        if (m_hit) m_ins = m_bd;
        else if (pc[31] && !suspend) begin
          m_busy = 1'b1;
          m_age = 0;
          m_req = 1'b1;
          m_addr = {pc[31:2], 2'b00};
        end
      end
    end
  endtask
  initial begin
    logic prev;
    logic [31:0] cur;
    tbl[0]  = '{A, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, A};
    tbl[1]  = '{A, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, A};
    tbl[2]  = '{A, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{A, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093, 32'h0};
    tbl[4]  = '{A, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093, 32'h0};
    tbl[5]  = '{A, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093, 32'h0};
    tbl[6]  = '{B, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, B};
    tbl[7]  = '{B, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, B};
    tbl[8]  = '{B, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{B, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 32'h0};
    tbl[10] = '{A, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, A};
    tbl[11] = '{C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, A};
    tbl[12] = '{C, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[14] = '{C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, C};
    tbl[15] = '{C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, C};
    tbl[16] = '{C, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[17] = '{C, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[18] = '{C | 32'h3, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[19] = '{C | 32'h3, 1'b1, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[20] = '{A, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, A};
    pcs = '{A, B, C, 32'h0000_0100, 32'h8000_0042};
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("rst_req", ext_req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_valid_reg", valid_reg, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_instr", instr, 0);
    chk("rst_addr", ext_addr, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
      chk("int_req", ext_req, 0);
      chk("int_valid", valid, 0);
    end
    prev = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(1'b0, tbl[i].pc, 1'b0, tbl[i].ack, tbl[i].rd);
      chk($sformatf("vec%0d_req", i), ext_req, tbl[i].req);
      chk($sformatf("vec%0d_valid", i), valid, tbl[i].val);
      chk($sformatf("vec%0d_valid_reg", i), valid_reg, prev);
      if (tbl[i].val) chk($sformatf("vec%0d_instr", i), instr, tbl[i].ins);
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), ext_addr, tbl[i].addr);
      prev = tbl[i].val;
    end
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h8000_0200, 1'b0, 1'b0, 32'h0);
      chk("to_req_held", ext_req, 1);
    end
    step(1'b0, 32'h8000_0200, 1'b0, 1'b0, 32'h0);
    chk("to_req_drop", ext_req, 0);
    chk("to_err", fetch_err, 1);
    chk("to_valid", valid, 1);
    chk("to_instr", instr, NOP);
    step(1'b0, 32'h8000_0200, 1'b1, 1'b0, 32'h0);
    chk("to_after_valid", valid, 0);
    chk("to_after_req", ext_req, 0);
    step(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);
    chk("to_err_sticky", fetch_err, 1);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("to_err_reset", fetch_err, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h8000_0300, 1'b0, 1'b0, 32'h0);
      chk("aw_req_held", ext_req, 1);
    end
    step(1'b0, 32'h8000_0300, 1'b0, 1'b1, 32'h1234_5678);
    chk("aw_req_drop", ext_req, 0);
    chk("aw_no_err", fetch_err, 0);
    step(1'b0, 32'h8000_0300, 1'b0, 1'b0, 32'h0);
    chk("aw_valid", valid, 1);
    chk("aw_instr", instr, 32'h1234_5678);
    chk("aw_err", fetch_err, 0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h8000_0400, 1'b1, 1'b0, 32'h0);
      chk("sus_req", ext_req, 0);
      chk("sus_valid", valid, 0);
    end
    step(1'b0, 32'h8000_0400, 1'b0, 1'b0, 32'h0);
    chk("sus_release_req", ext_req, 1);
    chk("sus_release_addr", ext_addr, 32'h8000_0400);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h8000_0500, 1'b0, 1'b0, 32'h0);
    chk("rm_req", ext_req, 1);
    step(1'b0, 32'h8000_0500, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h8000_0500, 1'b0, 1'b0, 32'h0);
    chk("rm_req_reset", ext_req, 0);
    step(1'b0, 32'h8000_0500, 1'b1, 1'b1, 32'h77);
    chk("rm_ack_ignored_req", ext_req, 0);
    step(1'b0, 32'h8000_0500, 1'b1, 1'b0, 32'h0);
    chk("rm_ack_ignored_valid", valid, 0);
    cur = A;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) cur = pcs[$urandom_range(4)];
      step(i == 0 || $urandom_range(99) == 0, cur, $urandom_range(4) == 0,
           $urandom_range(2) == 0, $urandom);
      model_edge();
      chk("rnd_req", ext_req, m_req);
      chk("rnd_valid", valid, m_val);
      chk("rnd_valid_reg", valid_reg, m_vr);
      chk("rnd_err", fetch_err, m_err);
      if (m_val) chk("rnd_instr", instr, m_ins);
      if (m_req) chk("rnd_addr", ext_addr, m_addr);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
